// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer for an 8259A-compatible PIC in 8086 mode (two INTA pulses).
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   inta_n          CPU interrupt acknowledge (active low, asynchronous to clk)
//   sp              1 = master, 0 = slave
//   icw2            vector base, bits [7:3] used
//   icw3            master: bit n set = slave attached on IR n
//   aeoi            automatic EOI enable
//   irq_valid       priority resolver has a pending unmasked request
//   irq_level       highest-priority pending level
//   slave_flag      cascade controller: this slave is addressed
//   int_out         INT request to the CPU
//   cas_strobe      one-cycle control pulse to the cascade controller
//   desired_slave   slave ID for the cascade controller (master mode)
//   freeze          hold IRR/priority inputs stable during the acknowledge
//   isr_set         one-hot, one-cycle ISR set pulse
//   isr_clr         one-hot, one-cycle ISR clear pulse (AEOI)
//   data_out        vector byte
//   data_oe         data bus drive enable
//   busy            any state other than idle
module inta_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inta_n,
    input  logic       sp,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic       aeoi,
    input  logic       irq_valid,
    input  logic [2:0] irq_level,
    input  logic       slave_flag,
    output logic       int_out,
    output logic       cas_strobe,
    output logic [2:0] desired_slave,
    output logic       freeze,
    output logic [7:0] isr_set,
    output logic [7:0] isr_clr,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy
);

    typedef enum logic [2:0] {StIdle, StReq, StAck1, StGap, StAck2} state_e;

    localparam logic [7:0] TimeoutLast = 8'(ACK_TIMEOUT - 1);

    // inta_n synchroniser plus one history flop for edge detection
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   inta_sync;
    logic                   fall;
    logic                   rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], inta_n};
            hist_q <= inta_sync;
        end
    end

    assign inta_sync = sync_q[SYNC_STAGES-1];
    assign fall      = hist_q & ~inta_sync;
    assign rise      = ~hist_q & inta_sync;

    state_e     state_q, state_d;
    logic       int_out_q, int_out_d;
    logic       freeze_q, freeze_d;
    logic [2:0] desired_slave_q, desired_slave_d;
    logic       cas_pend_q, cas_pend_d;
    logic       cas_strobe_q, cas_strobe_d;
    logic [7:0] isr_set_q, isr_set_d;
    logic [7:0] isr_clr_q, isr_clr_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;
    logic [2:0] level_q, level_d;
    logic       spurious_q, spurious_d;
    logic [7:0] cnt_q, cnt_d;

    // Level/spurious as they will be latched at the first INTA fall
    logic [2:0] new_level;
    logic       new_cascaded;
    logic       drive;
    logic       unused_icw2;

    assign new_level    = irq_valid ? irq_level : 3'd7;
    assign new_cascaded = sp & icw3[new_level] & irq_valid;
    // Master drives the vector unless a slave owns it; a slave drives only when addressed
    assign drive        = sp ? ~(icw3[level_q] & ~spurious_q) : slave_flag;
    assign unused_icw2  = ^icw2[2:0];

    always_comb begin
        state_d         = state_q;
        int_out_d       = int_out_q;
        freeze_d        = freeze_q;
        desired_slave_d = desired_slave_q;
        cas_pend_d      = 1'b0;
        cas_strobe_d    = cas_pend_q;
        isr_set_d       = 8'd0;
        isr_clr_d       = 8'd0;
        data_out_d      = data_out_q;
        data_oe_d       = data_oe_q;
        level_d         = level_q;
        spurious_d      = spurious_q;
        cnt_d           = cnt_q;

        case (state_q)
            StIdle: begin
                if (irq_valid) begin
                    state_d   = StReq;
                    int_out_d = 1'b1;
                end
            end
            StReq: begin
                if (fall) begin
                    state_d    = StAck1;
                    int_out_d  = 1'b0;
                    freeze_d   = 1'b1;
                    level_d    = new_level;
                    spurious_d = ~irq_valid;
                    if (irq_valid) begin
                        isr_set_d = 8'd1 << irq_level;
                    end
                    // Strobe lags desired_slave by one cycle so the ID is settled
                    if (new_cascaded) begin
                        desired_slave_d = new_level;
                        cas_pend_d      = 1'b1;
                    end
                end
            end
            StAck1: begin
                if (rise) begin
                    state_d = StGap;
                    cnt_d   = 8'd0;
                    if (!sp) begin
                        cas_strobe_d = 1'b1;
                    end
                end
            end
            StGap: begin
                if (fall) begin
                    state_d = StAck2;
                    if (drive) begin
                        data_oe_d  = 1'b1;
                        data_out_d = {icw2[7:3], level_q};
                    end else begin
                        data_oe_d  = 1'b0;
                        data_out_d = 8'd0;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    state_d         = StIdle;
                    freeze_d        = 1'b0;
                    desired_slave_d = 3'd0;
                    cnt_d           = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StAck2: begin
                if (rise) begin
                    state_d         = StIdle;
                    data_oe_d       = 1'b0;
                    data_out_d      = 8'd0;
                    freeze_d        = 1'b0;
                    desired_slave_d = 3'd0;
                    if (aeoi && !spurious_q) begin
                        isr_clr_d = 8'd1 << level_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            int_out_q       <= 1'b0;
            freeze_q        <= 1'b0;
            desired_slave_q <= 3'd0;
            cas_pend_q      <= 1'b0;
            cas_strobe_q    <= 1'b0;
            isr_set_q       <= 8'd0;
            isr_clr_q       <= 8'd0;
            data_out_q      <= 8'd0;
            data_oe_q       <= 1'b0;
            level_q         <= 3'd0;
            spurious_q      <= 1'b0;
            cnt_q           <= 8'd0;
        end else begin
            state_q         <= state_d;
            int_out_q       <= int_out_d;
            freeze_q        <= freeze_d;
            desired_slave_q <= desired_slave_d;
            cas_pend_q      <= cas_pend_d;
            cas_strobe_q    <= cas_strobe_d;
            isr_set_q       <= isr_set_d;
            isr_clr_q       <= isr_clr_d;
            data_out_q      <= data_out_d;
            data_oe_q       <= data_oe_d;
            level_q         <= level_d;
            spurious_q      <= spurious_d;
            cnt_q           <= cnt_d;
        end
    end

    assign int_out       = int_out_q;
    assign cas_strobe    = cas_strobe_q;
    assign desired_slave = desired_slave_q;
    assign freeze        = freeze_q;
    assign isr_set       = isr_set_q;
    assign isr_clr       = isr_clr_q;
    assign data_out      = data_out_q;
    assign data_oe       = data_oe_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: stimulus pushes the expected output events of each
// acknowledge into a queue, a negedge monitor pops and compares whenever the DUT emits one.
module tb_inta_sequencer;

    localparam int unsigned AckTimeout = 255;

    localparam int KSet  = 0;
    localparam int KCas  = 1;
    localparam int KData = 2;
    localparam int KClr  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       inta_n;
    logic       sp;
    logic [7:0] icw2;
    logic [7:0] icw3;
    logic       aeoi;
    logic       irq_valid;
    logic [2:0] irq_level;
    logic       slave_flag;
    logic       int_out;
    logic       cas_strobe;
    logic [2:0] desired_slave;
    logic       freeze;
    logic [7:0] isr_set;
    logic [7:0] isr_clr;
    logic [7:0] data_out;
    logic       data_oe;
    logic       busy;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    logic prev_oe = 1'b0;

    inta_sequencer #(
        .SYNC_STAGES(2),
        .ACK_TIMEOUT(AckTimeout)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inta_n       (inta_n),
        .sp           (sp),
        .icw2         (icw2),
        .icw3         (icw3),
        .aeoi         (aeoi),
        .irq_valid    (irq_valid),
        .irq_level    (irq_level),
        .slave_flag   (slave_flag),
        .int_out      (int_out),
        .cas_strobe   (cas_strobe),
        .desired_slave(desired_slave),
        .freeze       (freeze),
        .isr_set      (isr_set),
        .isr_clr      (isr_clr),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic string kname(input int k);
        case (k)
            KSet:    return "isr_set";
            KCas:    return "cas_strobe";
            KData:   return "vector";
            default: return "isr_clr";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [7:0] val);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got %s=%02h, required no event at %0t",
                     kname(kind), val, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                n_err++;
                $display("FAIL event: got %s=%02h, required %s=%02h at %0t",
                         kname(kind), val, kname(e.kind), e.val, $time);
            end
        end
    endtask

    // Monitor: every DUT output event is matched against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            prev_oe <= 1'b0;
        end else begin
            if (isr_set != 8'd0) observe(KSet, isr_set);
            if (cas_strobe) observe(KCas, {5'd0, desired_slave});
            if (data_oe && !prev_oe) observe(KData, data_out);
            if (isr_clr != 8'd0) observe(KClr, isr_clr);
            prev_oe <= data_oe;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_int();
        for (int i = 0; i < 8 && !int_out; i++) tick();
        @(negedge clk);
        check("int_out_raised", {31'd0, int_out}, 32'd1);
    endtask

    // Reference model: which events one acknowledge must produce, and in what order
    task automatic run_txn(input logic t_sp, input logic [7:0] t_icw2, input logic [7:0] t_icw3,
                           input logic t_aeoi, input logic [2:0] t_level, input logic t_valid,
                           input logic t_flag, input logic t_complete);
        logic       spur;
        logic       casc;
        logic       drv;
        logic [2:0] lvl;
        spur = !t_valid;
        lvl  = spur ? 3'd7 : t_level;
        casc = t_sp && t_icw3[lvl] && !spur;
        drv  = t_sp ? !casc : t_flag;
        if (!spur) push(KSet, 8'd1 << lvl);
        if (casc) push(KCas, {5'd0, lvl});
        if (!t_sp) push(KCas, 8'd0);
        if (t_complete && drv) push(KData, {t_icw2[7:3], lvl});
        if (t_complete && t_aeoi && !spur) push(KClr, 8'd1 << lvl);

        sp         = t_sp;
        icw2       = t_icw2;
        icw3       = t_icw3;
        aeoi       = t_aeoi;
        irq_level  = t_level;
        slave_flag = t_flag;
        irq_valid  = 1'b1;
        wait_int();
        if (spur) begin
            irq_valid = 1'b0;
            repeat (3) tick();
            @(negedge clk);
            check("int_out_held", {31'd0, int_out}, 32'd1);
        end

        inta_n = 1'b0;
        repeat ($urandom_range(8, 5)) tick();
        @(negedge clk);
        check("ack1_freeze", {31'd0, freeze}, 32'd1);
        check("ack1_int_low", {31'd0, int_out}, 32'd0);
        tick();
        inta_n    = 1'b1;
        irq_valid = 1'b0;
        repeat ($urandom_range(10, 4)) tick();

        if (t_complete) begin
            inta_n = 1'b0;
            repeat ($urandom_range(8, 5)) tick();
            @(negedge clk);
            check("ack2_data_oe", {31'd0, data_oe}, {31'd0, drv});
            tick();
            inta_n = 1'b1;
            repeat (6) tick();
            @(negedge clk);
            check("done_busy", {31'd0, busy}, 32'd0);
            check("done_freeze", {31'd0, freeze}, 32'd0);
            check("done_data_oe", {31'd0, data_oe}, 32'd0);
            check("done_desired_slave", {29'd0, desired_slave}, 32'd0);
        end else begin
            repeat (AckTimeout + 8) tick();
            @(negedge clk);
            check("timeout_busy", {31'd0, busy}, 32'd0);
            check("timeout_freeze", {31'd0, freeze}, 32'd0);
            check("timeout_desired_slave", {29'd0, desired_slave}, 32'd0);
            inta_n = 1'b0;
            repeat (6) tick();
            @(negedge clk);
            check("late_inta_data_oe", {31'd0, data_oe}, 32'd0);
            check("late_inta_busy", {31'd0, busy}, 32'd0);
            tick();
            inta_n = 1'b1;
            repeat (6) tick();
        end
        @(negedge clk);
        check("events_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        inta_n     = 1'b1;
        sp         = 1'b1;
        icw2       = 8'h00;
        icw3       = 8'h00;
        aeoi       = 1'b0;
        irq_valid  = 1'b0;
        irq_level  = 3'd0;
        slave_flag = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_int_out", {31'd0, int_out}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_data_oe", {31'd0, data_oe}, 32'd0);
        check("reset_freeze", {31'd0, freeze}, 32'd0);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Directed cases
        run_txn(1'b1, 8'h40, 8'h00, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1);
        run_txn(1'b1, 8'h40, 8'h08, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1);
        run_txn(1'b0, 8'h70, 8'h00, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1);
        run_txn(1'b0, 8'h70, 8'h00, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1);
        run_txn(1'b1, 8'h40, 8'h80, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1);
        run_txn(1'b1, 8'h40, 8'h00, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);

        // Reset while the vector is on the bus
        push(KSet, 8'h40);
        push(KData, 8'h9e);
        sp        = 1'b1;
        icw2      = 8'h98;
        icw3      = 8'h00;
        aeoi      = 1'b0;
        irq_level = 3'd6;
        irq_valid = 1'b1;
        wait_int();
        inta_n = 1'b0;
        repeat (6) tick();
        inta_n    = 1'b1;
        irq_valid = 1'b0;
        repeat (6) tick();
        inta_n = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        check("pre_reset_data_oe", {31'd0, data_oe}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_data_oe", {31'd0, data_oe}, 32'd0);
        check("rst_freeze", {31'd0, freeze}, 32'd0);
        check("rst_int_out", {31'd0, int_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        inta_n = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_events_drained", exp_q.size(), 32'd0);
        run_txn(1'b1, 8'h98, 8'h00, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1);

        // Randomised acknowledges
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(1, 0)), 8'($urandom), 8'($urandom), 1'($urandom_range(1, 0)),
                    3'($urandom_range(7, 0)), ($urandom_range(7, 0) != 0),
                    1'($urandom_range(1, 0)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- Interrupt-acknowledge sequencer for the 8259A-compatible PIC, 8086 mode (two INTA pulses).
- Sits between the priority resolver and the cascade controller.
- Raises INT, tracks the INTA pulse sequence, freezes the request latch, pulses ISR set/clear, and drives the cascade controller's control_signal and desired_slave.
- Places the interrupt vector on the data bus when this device owns the vector.

Parameters:
SYNC_STAGES, 2, number of flops synchronising inta_n to clk (min 2)
ACK_TIMEOUT, 255, clk cycles allowed between INTA pulses before abort (8-bit counter)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
inta_n  input  1  CPU interrupt acknowledge, active low, asynchronous to clk
sp  input  1  1 = MASTER, 0 = SLAVE
icw2  input  8  vector base; bits [7:3] used
icw3  input  8  master: bit n = slave on IR n; slave: unused here
aeoi  input  1  automatic EOI enable (ICW4)
irq_valid  input  1  priority resolver has a pending unmasked request
irq_level  input  3  highest-priority pending level
slave_flag  input  1  cascade controller flag: this slave is addressed
int_out  output  1  INT request to CPU
cas_strobe  output  1  control_signal to cascade controller (one-cycle pulse)
desired_slave  output  3  slave ID for cascade controller (master mode)
freeze  output  1  hold IRR/priority inputs stable during acknowledge
isr_set  output  8  one-hot, one-cycle pulse setting an ISR bit
isr_clr  output  8  one-hot, one-cycle pulse clearing an ISR bit (AEOI)
data_out  output  8  vector byte
data_oe  output  1  data bus drive enable
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous): all outputs 0; state IDLE; synchroniser flops 1 (inta_n inactive); timeout counter 0; latched level 0; spurious 0.
- Synchroniser: inta_n passes through SYNC_STAGES flops, plus one history flop.
  - fall = history 1 and synchronised 0; rise = history 0 and synchronised 1.
  - fall and rise are single-cycle events.
- States: IDLE, REQ, ACK1, GAP, ACK2.
- IDLE:
  - irq_valid=1 -> REQ.
  - int_out=1 from the next cycle.
  - fall in IDLE is ignored.
- REQ:
  - int_out held 1 even if irq_valid drops.
  - fall -> ACK1.
- Entry to ACK1 (the cycle fall is seen):
  - int_out<=0, freeze<=1.
  - irq_valid=1: level<=irq_level, spurious<=0.
  - irq_valid=0: level<=7, spurious<=1.
  - Next cycle: isr_set=one-hot(level) for 1 cycle; suppressed if spurious.
  - MASTER and icw3[level]=1 and not spurious:
    - desired_slave<=level.
    - cas_strobe=1 for exactly 1 cycle, one cycle after desired_slave is valid.
- ACK1:
  - rise -> GAP; timeout counter cleared.
  - SLAVE: cas_strobe=1 for 1 cycle on GAP entry, so the cascade controller samples CAS while it is stable.
- GAP:
  - Counter increments each cycle.
  - fall -> ACK2.
  - Counter reaching ACK_TIMEOUT -> IDLE, with freeze<=0, desired_slave<=0, no isr_clr, no data drive.
- ACK2 drive decision (made at the fall):
  - MASTER: drive = not (icw3[level]=1 and not spurious).
  - SLAVE: drive = slave_flag.
  - If drive: data_out={icw2[7:3],level} and data_oe=1 from the cycle after the fall until the cycle after the rise; otherwise data_oe=0 and data_out=0.
- ACK2 on rise -> IDLE, plus:
  - data_oe<=0, freeze<=0, desired_slave<=0.
  - aeoi=1 and not spurious: isr_clr=one-hot(level) for 1 cycle.
- Return to REQ: after returning to IDLE, a still-valid irq_valid re-enters REQ the following cycle; there is no same-cycle re-arm.
- Event ordering:
  - fall and rise cannot coincide, by construction of the synchroniser.
  - isr_set and isr_clr never pulse in the same cycle.
- Reset mid-operation: all outputs drop to 0 immediately; any partial acknowledge is discarded.

Test Plan:
- MASTER, icw2=0x40, icw3=0x00, irq_level=5 -> int_out rises; after first INTA pulse, isr_set=0x20; second INTA -> data_out=0x45 with data_oe=1 during the pulse; with aeoi=1, isr_clr=0x20 after the rise.
- MASTER, icw3=0x08, irq_level=3 -> desired_slave=3 with one cas_strobe pulse in ACK1; isr_set=0x08; second INTA -> data_oe stays 0.
- SLAVE, icw2=0x70, irq_level=2:
  - slave_flag=1 -> cas_strobe pulse on GAP entry; data_out=0x72 on second INTA.
  - Repeat with slave_flag=0 -> data_oe stays 0.
- Spurious: irq_valid dropped before first INTA -> isr_set stays 0; second INTA -> data_out={icw2[7:3],3'b111}; no isr_clr even with aeoi=1.
- Timeout: first INTA then no second pulse for ACK_TIMEOUT cycles -> state IDLE, freeze=0, busy=0; a late INTA pulse drives nothing.
- Reset asserted in ACK2 with data_oe=1 -> data_oe, freeze, int_out, busy all 0 immediately; normal sequence succeeds after release.
